exe_div_unit: RTL and testbench
===============================

// Module: exe_div_unit
// PURPOSE
//  Iterative 32-bit radix-2 restoring divider used by the EXE stage for DIV/DIVU.
//  It consumes the src1/src2 operands the decode stage delivers through the ID/EXE register.
//  It holds EXE through stallreq_exe until the quotient (->LO) and remainder (->HI) are ready.
//  One quotient bit is produced per cycle. Pipeline flush aborts it.
// PARAMETERS
//  DATA_W   32   operand/result width; CNT_W = $clog2(DATA_W)
// PORTS
//  cpu_clk_50M    in   1       system clock, rising edge
//  cpu_rst        in   1       asynchronous reset, active-high
//  div_start_i    in   1       EXE holds a DIV/DIVU; held high while stalled
//  div_signed_i   in   1       1=DIV (two's complement), 0=DIVU
//  div_src1_i     in   DATA_W  dividend (rs)
//  div_src2_i     in   DATA_W  divisor (rt)
//  flush_i        in   1       pipeline flush (exception/ERET); aborts operation
//  div_lo_o       out  DATA_W  quotient, valid while div_ready_o
//  div_hi_o       out  DATA_W  remainder, valid while div_ready_o
//  div_ready_o    out  1       one-cycle result-valid pulse (state DONE)
//  stallreq_exe   out  1       = div_start_i & ~div_ready_o & ~flush_i (combinational)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, all datapath regs 0, div_lo_o=div_hi_o=0, div_ready_o=0.
//   Reset may assert in any state and returns to IDLE immediately.
//  States: IDLE, BUSY, DONE.
//  IDLE:
//   - start=1 & ~flush & divisor!=0: latch |src1|, |src2| (abs only if signed),
//     latch sign flags, clear partial remainder, cnt=0 -> BUSY.
//   - start=1 & divisor==0: -> DONE with q=32'hFFFF_FFFF, r=src1.
//   - otherwise: stay in IDLE.
//  BUSY, per cycle:
//   - {rem,quo} shifted left 1.
//   - trial = rem_shifted - divisor (DATA_W+1 bits).
//   - if trial >= 0: rem=trial, quo[0]=1; else quo[0]=0.
//   - cnt++. The cycle with cnt==DATA_W-1 -> DONE.
//  BUSY->DONE edge: sign fix applied and results registered.
//   - q negated iff signed & sign(src1)!=sign(src2); r negated iff signed & src1<0.
//  DONE: div_ready_o=1 for exactly one cycle; outputs hold their values afterwards.
//   - Always -> IDLE next edge, regardless of start.
//   - The same instruction is never restarted: the stall drops in DONE, so EXE advances on that edge.
//  Latency: start first seen in cycle 0 -> ready in cycle DATA_W+1 (33).
//   stallreq_exe is high in cycles 0..32. Divide-by-zero: ready in cycle 1.
//  Abort: flush_i=1, or div_start_i=0 while BUSY -> IDLE next edge, no ready pulse,
//   results unchanged. Flush has priority over start in IDLE.
//  Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF -> q=0x8000_0000, r=0 (no trap).
//  Back-to-back DIVs: the second DIV starts in the IDLE cycle right after DONE.
// TESTING
//  DIVU 100/7, start held -> ready in cycle 33, lo=14, hi=2; stallreq high cycles 0..32.
//  DIV -7/2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
//  DIV 7/-2 -> lo=0xFFFF_FFFD, hi=1.
//  DIVU 0xFFFF_FFFF/1 -> lo=0xFFFF_FFFF, hi=0.
//  DIV 0x8000_0000/-1 -> lo=0x8000_0000, hi=0.
//  DIV 7/0 -> ready in cycle 1, lo=0xFFFF_FFFF, hi=7; stall lasts 1 cycle.
//  flush_i at cycle 10 of BUSY -> IDLE next cycle, no ready; a new 9/3 then gives lo=3, hi=0.
//  cpu_rst pulse mid-BUSY -> outputs 0 and IDLE asynchronously.
//  Two consecutive DIVs 20/6 then 20/7 -> ready pulses 34 cycles apart, values 3/2 then 2/6.

Source files
------------

// File: rtl/exe_div_unit.sv
// exe_div_unit
//   Iterative radix-2 restoring divider for the EXE stage (DIV / DIVU).
//   Each BUSY cycle produces one quotient bit. EXE is held through
//   stallreq_exe until the one-cycle div_ready_o pulse. The quotient goes
//   to LO and the remainder goes to HI.
// Ports
//   cpu_clk_50M   in   system clock, rising edge
//   cpu_rst       in   asynchronous reset, active-high
//   div_start_i   in   EXE holds a DIV/DIVU; held high while stalled
//   div_signed_i  in   1 = DIV (two's complement), 0 = DIVU
//   div_src1_i    in   dividend (rs)
//   div_src2_i    in   divisor (rt)
//   flush_i       in   pipeline flush; aborts a running divide
//   div_lo_o      out  quotient, valid while div_ready_o (held afterwards)
//   div_hi_o      out  remainder, valid while div_ready_o (held afterwards)
//   div_ready_o   out  one-cycle result-valid pulse
//   stallreq_exe  out  stall request to the pipeline (combinational)
module exe_div_unit #(
  parameter int DATA_W = 32,
  localparam int CNT_W = $clog2(DATA_W)
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              div_start_i,
  input  logic              div_signed_i,
  input  logic [DATA_W-1:0] div_src1_i,
  input  logic [DATA_W-1:0] div_src2_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] div_lo_o,
  output logic [DATA_W-1:0] div_hi_o,
  output logic              div_ready_o,
  output logic              stallreq_exe
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_dvs;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_hi;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_ready;

  logic              w_go;
  logic              w_div_zero;
  logic              w_abort;
  logic              w_last;
  logic [DATA_W:0]   w_rem_sh;
  logic [DATA_W:0]   w_trial;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quo_nxt;

  // Two's complement negation.
  function automatic logic [DATA_W-1:0] neg_val(input logic [DATA_W-1:0] v);
    return {DATA_W{1'b0}} - v;
  endfunction

  // Magnitude of an operand; unsigned operands pass through unchanged.
  // The most negative value maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? neg_val(v) : v;
  endfunction

  assign w_go       = div_start_i & ~flush_i;
  assign w_div_zero = (div_src2_i == {DATA_W{1'b0}});
  assign w_abort    = flush_i | ~div_start_i;
  assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));

  // Shift {rem,quo} left by one and subtract the divisor. The sign bit of the
  // (DATA_W+1)-bit trial decides whether the subtraction is kept.
  assign w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_dvs};
  assign w_rem_nxt = w_trial[DATA_W] ? w_rem_sh[DATA_W-1:0] : w_trial[DATA_W-1:0];
  assign w_quo_nxt = {r_quo[DATA_W-2:0], ~w_trial[DATA_W]};

  assign div_lo_o     = r_lo;
  assign div_hi_o     = r_hi;
  assign div_ready_o  = r_ready;
  assign stallreq_exe = div_start_i & ~r_ready & ~flush_i;

  // State register.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. An abort in BUSY wins over completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_nxt = w_div_zero ? S_DONE : S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, sign fix-up and result registers.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_cnt   <= {CNT_W{1'b0}};
      r_rem   <= {DATA_W{1'b0}};
      r_quo   <= {DATA_W{1'b0}};
      r_dvs   <= {DATA_W{1'b0}};
      r_lo    <= {DATA_W{1'b0}};
      r_hi    <= {DATA_W{1'b0}};
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_go && w_div_zero) begin
            r_lo <= {DATA_W{1'b1}};
            r_hi <= div_src1_i;
          end else if (w_go) begin
            r_rem   <= {DATA_W{1'b0}};
            r_quo   <= abs_val(div_src1_i, div_signed_i);
            r_dvs   <= abs_val(div_src2_i, div_signed_i);
            r_neg_q <= div_signed_i & (div_src1_i[DATA_W-1] ^ div_src2_i[DATA_W-1]);
            r_neg_r <= div_signed_i & div_src1_i[DATA_W-1];
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_BUSY: begin
          if (!w_abort) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_last) begin
              r_lo <= r_neg_q ? neg_val(w_quo_nxt) : w_quo_nxt;
              r_hi <= r_neg_r ? neg_val(w_rem_nxt) : w_rem_nxt;
            end else begin
              r_lo <= r_lo;
            end
          end else begin
            r_cnt <= r_cnt;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_div_unit.sv
// tb_exe_div_unit
//   Self-checking bench for exe_div_unit: directed cases, abort paths,
//   asynchronous reset, back-to-back operation and random operands compared
//   against an arithmetic reference model.
module tb_exe_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] s1;
  logic [31:0] s2;
  logic        flush;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        ready;
  logic        stall;

  int vectors;
  int miscompares;

  // Results the DUT is expected to hold after the most recent completed divide.
  logic [31:0] g_lo;
  logic [31:0] g_hi;

  exe_div_unit #(.DATA_W(32)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .div_start_i (start),
    .div_signed_i(sgn),
    .div_src1_i  (s1),
    .div_src2_i  (s2),
    .flush_i     (flush),
    .div_lo_o    (lo),
    .div_hi_o    (hi),
    .div_ready_o (ready),
    .stallreq_exe(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 64-bit arithmetic, truncating division, remainder takes the dividend's sign.
  function automatic void model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint la;
    longint lb;
    longint lq;
    longint lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      if (sg) begin
        la = {{32{a[31]}}, a};
        lb = {{32{b[31]}}, b};
      end else begin
        la = {32'd0, a};
        lb = {32'd0, b};
      end
      lq = la / lb;
      lr = la % lb;
      q  = lq[31:0];
      r  = lr[31:0];
    end
  endfunction

  // Issue one divide (called just after a falling edge) and follow it to the ready pulse.
  // Returns just after the ready cycle's falling edge with div_start_i still high.
  task automatic do_div(input string name, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_q, input logic [31:0] exp_r);
    int exp_rc;
    int rc;
    exp_rc = (b == 32'd0) ? 1 : 33;
    rc     = -1;
    start  = 1'b1;
    sgn    = sg;
    s1     = a;
    s2     = b;
    flush  = 1'b0;
    for (int c = 0; c < 40 && rc < 0; c++) begin
      #1;
      vectors++;
      if (stall !== (c < exp_rc)) begin
        miscompares++;
        $display("FAIL %s stall cycle %0d: got %b expected %b", name, c, stall, (c < exp_rc));
      end
      if (ready === 1'b1) begin
        rc = c;
      end else begin
        @(negedge clk);
      end
    end
    vectors++;
    if (rc != exp_rc) begin
      miscompares++;
      $display("FAIL %s latency: got %0d expected %0d", name, rc, exp_rc);
    end
    vectors++;
    if (lo !== exp_q) begin
      miscompares++;
      $display("FAIL %s lo: got %h expected %h", name, lo, exp_q);
    end
    vectors++;
    if (hi !== exp_r) begin
      miscompares++;
      $display("FAIL %s hi: got %h expected %h", name, hi, exp_r);
    end
    g_lo = exp_q;
    g_hi = exp_r;
  endtask

  // Step past the ready cycle with start released; pulse must be gone, results held.
  task automatic finish_op(input string name);
    @(negedge clk);
    start = 1'b0;
    #1;
    vectors++;
    if (ready !== 1'b0 || lo !== g_lo || hi !== g_hi) begin
      miscompares++;
      $display("FAIL %s hold: got ready=%b lo=%h hi=%h expected ready=0 lo=%h hi=%h",
               name, ready, lo, hi, g_lo, g_hi);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    s1    = 32'd0;
    s2    = 32'd0;
    flush = 1'b0;
    #3;
    vectors++;
    if (lo !== 32'd0 || hi !== 32'd0 || ready !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got lo=%h hi=%h ready=%b stall=%b expected all 0", lo, hi, ready, stall);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_directed();
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    finish_op("divu_100_7");
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    finish_op("div_m7_2");
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    finish_op("div_7_m2");
    do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    finish_op("divu_max_1");
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    finish_op("div_ovf");
    do_div("div_by_zero", 1'b1, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7);
    finish_op("div_by_zero");
  endtask

  // Flush in BUSY cycle 10; a new divide presented on the next cycle must take full latency.
  task automatic test_flush();
    @(negedge clk);
    start = 1'b1;
    sgn   = 1'b0;
    s1    = 32'd100;
    s2    = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0 || ready !== 1'b0 || lo !== g_lo || hi !== g_hi) begin
      miscompares++;
      $display("FAIL flush cycle: got stall=%b ready=%b lo=%h hi=%h expected 0 0 %h %h",
               stall, ready, lo, hi, g_lo, g_hi);
    end
    @(negedge clk);
    do_div("after_flush_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
    finish_op("after_flush_9_3");
  endtask

  // Dropping start in BUSY aborts silently.
  task automatic test_start_drop();
    @(negedge clk);
    start = 1'b1;
    sgn   = 1'b1;
    s1    = 32'd1000;
    s2    = 32'd9;
    repeat (5) @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (ready !== 1'b0 || lo !== g_lo || hi !== g_hi) begin
        miscompares++;
        $display("FAIL start_drop cycle %0d: got ready=%b lo=%h hi=%h expected 0 %h %h",
                 c, ready, lo, hi, g_lo, g_hi);
      end
    end
    @(negedge clk);
    do_div("after_drop_1000_9", 1'b1, 32'd1000, 32'd9, 32'd111, 32'd1);
    finish_op("after_drop_1000_9");
  endtask

  // Asynchronous reset in the middle of BUSY.
  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    sgn   = 1'b0;
    s1    = 32'd100;
    s2    = 32'd7;
    repeat (6) @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    #1;
    vectors++;
    if (lo !== 32'd0 || hi !== 32'd0 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got lo=%h hi=%h ready=%b expected 0 0 0", lo, hi, ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_div("after_reset_20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2);
    finish_op("after_reset_20_6");
  endtask

  // Second divide presented in the IDLE cycle right after DONE: pulses 34 cycles apart.
  task automatic test_back_to_back();
    @(negedge clk);
    do_div("b2b_20_6", 1'b1, 32'd20, 32'd6, 32'd3, 32'd2);
    @(negedge clk);
    do_div("b2b_20_7", 1'b1, 32'd20, 32'd7, 32'd2, 32'd6);
    finish_op("b2b_20_7");
  endtask

  task automatic test_random();
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    for (int i = 0; i < 30; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       begin b = $urandom; a = 32'h8000_0000; end
        4:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      model(sg, a, b, q, r);
      @(negedge clk);
      do_div("random", sg, a, b, q, r);
      finish_op("random");
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    g_lo        = 32'd0;
    g_hi        = 32'd0;
    test_reset();
    test_directed();
    test_flush();
    test_start_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
